// File: rtl/regfile_pkg.sv
// Shared register-file definitions used by the write-port arbiter and its bench.
package regfile_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned REG_DATA_W = 32;
    localparam int unsigned REG_COUNT  = 32;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    // One register-file write: destination and value.
    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [REG_DATA_W-1:0] data;
    } wr_req_t;

endpackage

// File: rtl/regfile_wr_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: the first requester at or after ptr
// (wrapping modulo N) wins. Produces a one-hot grant and its encoded index.
module rr_arbiter
    import regfile_pkg::*;
#(
    parameter int N  = 3,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx
);

    localparam int unsigned NU = N;

    logic          found;
    logic [IW-1:0] pos;

    // Scan N positions starting at ptr; keep the first valid one.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        pos   = '0;
        for (int unsigned k = 0; k < NU; k++) begin
            pos = IW'((32'(ptr) + k) % NU);
            if (!found && req[pos]) begin
                found    = 1'b1;
                gnt[pos] = 1'b1;
                idx      = pos;
            end
        end
    end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter sharing the register-file write port (we3/a3/wd3)
// among NUM_REQ writeback sources. Grant is combinational; the write port is
// driven from registers one cycle after the valid/ready handshake.
// Optional decode-stage forwarding ports: define REGFILE_WR_ARB_FWD_EN.
module regfile_wr_arbiter
    import regfile_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int DATA_W  = REG_DATA_W,
    parameter int ADDR_W  = REG_ADDR_W,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic                      we3,
    output logic [ADDR_W-1:0]         a3,
    output logic [DATA_W-1:0]         wd3,
    output logic [IDX_W-1:0]          grant_id
`ifdef REGFILE_WR_ARB_FWD_EN
    ,
    input  logic [ADDR_W-1:0]         fwd_a1,
    input  logic [ADDR_W-1:0]         fwd_a2,
    output logic                      fwd_hit1,
    output logic                      fwd_hit2,
    output logic [DATA_W-1:0]         fwd_data
`endif
);

    logic [ADDR_W-1:0] addr_arr [NUM_REQ];
    logic [DATA_W-1:0] data_arr [NUM_REQ];

    logic [NUM_REQ-1:0] gnt;
    logic [IDX_W-1:0]   gnt_idx;
    logic               hs;

    logic [IDX_W-1:0]   rr_ptr_q,   rr_ptr_d;
    logic               we3_q,      we3_d;
    logic [ADDR_W-1:0]  a3_q,       a3_d;
    logic [DATA_W-1:0]  wd3_q,      wd3_d;
    logic [IDX_W-1:0]   grant_id_q, grant_id_d;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign addr_arr[i] = req_addr[i*ADDR_W +: ADDR_W];
        assign data_arr[i] = req_data[i*DATA_W +: DATA_W];
    end

    rr_arbiter #(
        .N  (NUM_REQ),
        .IW (IDX_W)
    ) u_rr_arbiter (
        .req (req_valid),
        .ptr (rr_ptr_q),
        .gnt (gnt),
        .idx (gnt_idx)
    );

    // Grant is masked during reset so no request is acknowledged then.
    always_comb begin
        req_ready = reset ? '0 : gnt;
        hs        = |(req_valid & req_ready);
    end

    // Next-state for the pointer and the write-port registers.
    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        we3_d      = 1'b0;
        a3_d       = a3_q;
        wd3_d      = wd3_q;
        grant_id_d = grant_id_q;
        if (hs) begin
            rr_ptr_d   = (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + IDX_W'(1);
            // x0 writes are consumed but never reach the register file.
            we3_d      = (addr_arr[gnt_idx] != '0);
            a3_d       = addr_arr[gnt_idx];
            wd3_d      = data_arr[gnt_idx];
            grant_id_d = gnt_idx;
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rr_ptr_q   <= '0;
            we3_q      <= 1'b0;
            a3_q       <= '0;
            wd3_q      <= '0;
            grant_id_q <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            we3_q      <= we3_d;
            a3_q       <= a3_d;
            wd3_q      <= wd3_d;
            grant_id_q <= grant_id_d;
        end
    end

    assign we3      = we3_q;
    assign a3       = a3_q;
    assign wd3      = wd3_q;
    assign grant_id = grant_id_q;

`ifdef REGFILE_WR_ARB_FWD_EN
    // Bypass for the write landing this cycle; x0 never forwards.
    always_comb begin
        fwd_hit1 = we3_q && (a3_q == fwd_a1) && (fwd_a1 != '0);
        fwd_hit2 = we3_q && (a3_q == fwd_a2) && (fwd_a2 != '0);
        fwd_data = wd3_q;
    end
`else
    // No forwarding path in this build.
`endif

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter with a scoreboard of expected writes.
module tb_regfile_wr_arbiter;
    import regfile_pkg::*;

    localparam int NR = 3;

    logic         clock;
    logic         reset;
    logic [2:0]   req_valid;
    logic [2:0]   req_ready;
    logic [14:0]  req_addr;
    logic [95:0]  req_data;
    logic         we3;
    logic [4:0]   a3;
    logic [31:0]  wd3;
    logic [1:0]   grant_id;
`ifdef REGFILE_WR_ARB_FWD_EN
    logic [4:0]   fwd_a1, fwd_a2;
    logic         fwd_hit1, fwd_hit2;
    logic [31:0]  fwd_data;
`endif

    regfile_wr_arbiter #(
        .NUM_REQ (3),
        .DATA_W  (32),
        .ADDR_W  (5)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .we3       (we3),
        .a3        (a3),
        .wd3       (wd3),
        .grant_id  (grant_id)
`ifdef REGFILE_WR_ARB_FWD_EN
        ,
        .fwd_a1    (fwd_a1),
        .fwd_a2    (fwd_a2),
        .fwd_hit1  (fwd_hit1),
        .fwd_hit2  (fwd_hit2),
        .fwd_data  (fwd_data)
`endif
    );

    typedef struct {
        logic    we;
        wr_req_t req;
        logic [1:0] id;
    } exp_t;

    exp_t q[$];
    exp_t last;
    int   m_ptr;
    int   wait_cnt [NR];
    int   n_cmp = 0;
    int   n_err = 0;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ptr         = 0;
        last.we       = 1'b0;
        last.req.addr = '0;
        last.req.data = '0;
        last.id       = '0;
        q.delete();
        for (int i = 0; i < NR; i++) wait_cnt[i] = 0;
    endtask

    task automatic check_outputs();
        exp_t e;
        if (q.size() != 0) begin
            e = q.pop_front();
            chk("we3",      32'(we3),      32'(e.we));
            chk("a3",       32'(a3),       32'(e.req.addr));
            chk("wd3",      wd3,           e.req.data);
            chk("grant_id", 32'(grant_id), 32'(e.id));
        end
    endtask

    // One cycle: check last cycle's write, drive new requests, check the grant.
    task automatic step(input logic [2:0] v, input logic [14:0] a, input logic [95:0] d);
        int   w;
        exp_t e;
        @(negedge clock);
        check_outputs();
        req_valid = v;
        req_addr  = a;
        req_data  = d;
        #1;
        w = -1;
        for (int k = 0; k < NR; k++) begin
            int j;
            j = (m_ptr + k) % NR;
            if (w < 0 && v[j]) w = j;
        end
        chk("req_ready", 32'(req_ready), (w < 0) ? 32'd0 : (32'd1 << w));
        for (int i = 0; i < NR; i++) begin
            if (v[i] && !req_ready[i]) wait_cnt[i]++;
            else wait_cnt[i] = 0;
            chk("fairness_wait", 32'(wait_cnt[i] > NR - 1), 32'd0);
        end
        if (w < 0) begin
            e    = last;
            e.we = 1'b0;
        end else begin
            e.req.addr = a[w*5 +: 5];
            e.req.data = d[w*32 +: 32];
            e.we       = (e.req.addr != 5'd0);
            e.id       = 2'(w);
            m_ptr      = (w + 1) % NR;
        end
        last = e;
        q.push_back(e);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset     = 1'b1;
        req_valid = '0;
        model_reset();
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = '0;
        req_addr  = '0;
        req_data  = '0;
`ifdef REGFILE_WR_ARB_FWD_EN
        fwd_a1 = '0;
        fwd_a2 = '0;
`endif
        model_reset();

        // Reset held three cycles with no requests.
        repeat (3) begin
            @(negedge clock);
            chk("rst_we3",      32'(we3),       32'd0);
            chk("rst_a3",       32'(a3),        32'd0);
            chk("rst_wd3",      wd3,            32'd0);
            chk("rst_grant_id", 32'(grant_id),  32'd0);
            chk("rst_ready",    32'(req_ready), 32'd0);
        end
        req_valid = 3'b111;
        #1;
        chk("rst_ready_masked", 32'(req_ready), 32'd0);
        req_valid = '0;
        @(negedge clock);
        reset = 1'b0;

        // Single requester 1.
        step(3'b010, {5'd0, 5'd7, 5'd0}, {32'd0, 32'hDEADBEEF, 32'd0});
        step(3'b000, '0, '0);
        step(3'b000, '0, '0);

        // Contention from reset: 0,1,2,0,1,2.
        do_reset();
        repeat (6) step(3'b111, {5'd3, 5'd2, 5'd1}, {32'hC3C3C3C3, 32'hB2B2B2B2, 32'hA1A1A1A1});
        step(3'b000, '0, '0);
        step(3'b000, '0, '0);

        // x0 write consumed, pointer still advances.
        step(3'b001, {5'd0, 5'd0, 5'd0}, {32'd0, 32'd0, 32'h00001234});
        step(3'b011, {5'd0, 5'd9, 5'd4}, {32'd0, 32'h99999999, 32'h44444444});
        step(3'b001, {5'd0, 5'd9, 5'd4}, {32'd0, 32'h99999999, 32'h44444444});
        step(3'b000, '0, '0);

        // Asynchronous reset while a write is on the port.
        step(3'b001, {5'd0, 5'd0, 5'd6}, {32'd0, 32'd0, 32'h0000600D});
        @(posedge clock);
        #2;
        check_outputs();
        reset     = 1'b1;
        req_valid = '0;
        #1;
        chk("async_we3",      32'(we3),       32'd0);
        chk("async_a3",       32'(a3),        32'd0);
        chk("async_wd3",      wd3,            32'd0);
        chk("async_grant_id", 32'(grant_id),  32'd0);
        chk("async_ready",    32'(req_ready), 32'd0);
        model_reset();
        @(negedge clock);
        reset = 1'b0;
        step(3'b111, {5'd13, 5'd12, 5'd11}, {32'h33, 32'h22, 32'h11});
        step(3'b000, '0, '0);
        step(3'b000, '0, '0);

`ifdef REGFILE_WR_ARB_FWD_EN
        // Forwarding of the write landing this cycle.
        fwd_a1 = 5'd5;
        fwd_a2 = 5'd0;
        step(3'b001, {5'd0, 5'd0, 5'd5}, {32'd0, 32'd0, 32'hA5A5A5A5});
        req_valid = '0;
        @(posedge clock);
        #2;
        chk("fwd_hit1", 32'(fwd_hit1), 32'd1);
        chk("fwd_hit2", 32'(fwd_hit2), 32'd0);
        chk("fwd_data", fwd_data,      32'hA5A5A5A5);
        check_outputs();
        fwd_a1 = 5'd0;
        fwd_a2 = 5'd5;
        #1;
        chk("fwd_hit1_b", 32'(fwd_hit1), 32'd0);
        chk("fwd_hit2_b", 32'(fwd_hit2), 32'd1);
        step(3'b000, '0, '0);
`endif

        step(3'b000, '0, '0);
        @(negedge clock);
        check_outputs();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
